// File: rtl/piccolo_loader.sv
// Piccolo-128 front end: assembles key/plaintext from 16-bit words,
// pulses the core load, waits out its latency and returns the ciphertext.
module piccolo_loader #(
  parameter int CORE_LAT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_key,
  input  logic [15:0]  in_data,
  output logic [63:0]  core_plaintext,
  output logic [127:0] core_key,
  output logic         core_start,
  input  logic [63:0]  core_ciphertext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         key_loaded,
  output logic         err
);

  localparam int WW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [WW-1:0] LAST = WW'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    OUT
  } state_t;

  state_t        state;
  logic [2:0]    kcnt;
  logic [1:0]    pcnt;
  logic [WW-1:0] wcnt;

  // Word 0 lands in the most significant slice.
  logic [6:0] kidx;
  logic [5:0] pidx;
  assign kidx = 7'd127 - {kcnt, 4'd0};
  assign pidx = 6'd63 - {pcnt, 4'd0};

  assign in_ready = reset & (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      kcnt           <= '0;
      pcnt           <= '0;
      wcnt           <= '0;
      core_key       <= '0;
      core_plaintext <= '0;
      core_start     <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      key_loaded     <= 1'b0;
      err            <= 1'b0;
    end else begin
      core_start <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_key) begin
              core_key[kidx -: 16] <= in_data;
              kcnt <= kcnt + 3'd1;
              pcnt <= '0;
              if (kcnt == 3'd0) key_loaded <= 1'b0;
              if (kcnt == 3'd7) key_loaded <= 1'b1;
            end else begin
              core_plaintext[pidx -: 16] <= in_data;
              pcnt <= pcnt + 2'd1;
              if (pcnt == 2'd3) begin
                if (key_loaded) begin
                  state      <= START;
                  core_start <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
            end
          end
        end
        START: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: begin
          wcnt <= wcnt + WW'(1);
          if (wcnt == LAST) begin
            out_data  <= core_ciphertext;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piccolo_loader.sv
// Scoreboard bench for piccolo_loader: word-level reference model,
// stub core with a realistic output latency, decoupled output monitor.
module tb_piccolo_loader;

  localparam int LAT = 4;
  localparam logic [63:0] MASK = 64'hA5A5_A5A5_A5A5_A5A5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_key = 1'b0;
  logic [15:0]  in_data = '0;
  logic [63:0]  core_plaintext;
  logic [127:0] core_key;
  logic         core_start;
  logic [63:0]  core_ct = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_data;
  logic         key_loaded;
  logic         err;

  piccolo_loader #(.CORE_LAT(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_key(in_key),
    .in_data(in_data),
    .core_plaintext(core_plaintext),
    .core_key(core_key),
    .core_start(core_start),
    .core_ciphertext(core_ct),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .key_loaded(key_loaded),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stub core: output is junk until CORE_LAT cycles after the load edge.
  logic [63:0] spt = '0;
  int sc = 0;
  always @(posedge clk) begin
    if (core_start) begin
      spt <= core_plaintext;
      sc  <= 1;
      core_ct <= (LAT == 1) ? (core_plaintext ^ MASK)
                            : {$urandom, $urandom};
    end else if (sc > 0 && sc < LAT) begin
      core_ct <= (sc == LAT - 1) ? (spt ^ MASK) : {$urandom, $urandom};
      sc <= sc + 1;
    end
  end

  // Downstream: always ready, random, or held off.
  bit rnd = 0;
  bit bp_hold = 0;
  always begin
    @(posedge clk);
    #2;
    out_ready = bp_hold ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Reference model in terms of whole words and blocks.
  typedef struct {
    int           c;
    logic [127:0] k;
    logic [63:0]  p;
  } start_t;

  logic [15:0] mkey[8];
  logic [15:0] mpt[4];
  int mkn = 0;
  int mpn = 0;
  bit mkl = 0;

  start_t      start_q[$];
  int          vt_q[$];
  logic [63:0] ct_q[$];
  int          err_q[$];
  int          start_hist[$];

  function automatic void model_reset();
    mkn = 0;
    mpn = 0;
    mkl = 0;
    foreach (mkey[i]) mkey[i] = '0;
    foreach (mpt[i]) mpt[i] = '0;
  endfunction

  function automatic void model_word(input bit k, input logic [15:0] d,
                                     input int t);
    start_t s;
    if (k) begin
      if (mkn == 0) mkl = 0;
      mkey[mkn] = d;
      mkn = (mkn + 1) % 8;
      if (mkn == 0) mkl = 1;
      mpn = 0;
    end else begin
      mpt[mpn] = d;
      mpn++;
      if (mpn == 4) begin
        mpn = 0;
        if (mkl) begin
          s.c = t + 1;
          s.k = {mkey[0], mkey[1], mkey[2], mkey[3],
                 mkey[4], mkey[5], mkey[6], mkey[7]};
          s.p = {mpt[0], mpt[1], mpt[2], mpt[3]};
          start_q.push_back(s);
          vt_q.push_back(t + 2 + LAT);
          ct_q.push_back(s.p ^ MASK);
        end else begin
          err_q.push_back(t + 1);
        end
      end
    end
  endfunction

  // Monitor samples mid-cycle; inputs change just after the rising edge.
  bit          prev_ov = 0;
  bit          prev_hs = 0;
  logic [63:0] prev_od = '0;
  start_t      ms;
  int          me;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_ov = 0;
      prev_hs = 0;
    end else begin
      if (core_start) begin
        chk("start_expected", start_q.size() != 0, 1);
        if (start_q.size() != 0) begin
          ms = start_q.pop_front();
          chk("start_cycle", cyc, ms.c);
          chk("core_key", core_key, ms.k);
          chk("core_plaintext", core_plaintext, ms.p);
          start_hist.push_back(cyc);
        end
      end
      if (err) begin
        chk("err_expected", err_q.size() != 0, 1);
        chk("in_ready_on_err", in_ready, 1);
        if (err_q.size() != 0) begin
          me = err_q.pop_front();
          chk("err_cycle", cyc, me);
        end
      end
      if (prev_hs) begin
        chk("out_valid_after_hs", out_valid, 0);
        chk("in_ready_after_hs", in_ready, 1);
      end else if (out_valid && !prev_ov) begin
        chk("valid_expected", vt_q.size() != 0, 1);
        if (vt_q.size() != 0) chk("valid_cycle", cyc, vt_q.pop_front());
      end else if (out_valid) begin
        chk("out_data_stable", out_data, prev_od);
        chk("in_ready_low", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        chk("ct_expected", ct_q.size() != 0, 1);
        if (ct_q.size() != 0) chk("out_data", out_data, ct_q.pop_front());
      end
      prev_ov = out_valid;
      prev_od = out_data;
      prev_hs = out_valid && out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit k, input logic [15:0] d);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) begin
      chk("in_ready_timeout", in_ready, 1);
    end else begin
      in_valid = 1'b1;
      in_key   = k;
      in_data  = d;
      model_word(k, d, cyc);
      tick();
      in_valid = 1'b0;
      chk("key_loaded", key_loaded, mkl);
    end
  endtask

  task automatic block(input logic [63:0] p);
    send(0, p[63:48]);
    send(0, p[47:32]);
    send(0, p[31:16]);
    send(0, p[15:0]);
  endtask

  task automatic drain();
    int n = 0;
    while ((start_q.size() != 0 || vt_q.size() != 0 || ct_q.size() != 0 ||
            err_q.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    chk("drain", n < 300, 1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_key_loaded", key_loaded, 0);
    chk("rst_err", err, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_pt", core_plaintext, 0);
    reset = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    tick();

    // Plaintext without a key
    block(64'h1111_2222_3333_4444);
    drain();
    chk("nokey_key_loaded", key_loaded, 0);

    // Key then block
    for (int i = 0; i < 8; i++) send(1, 16'h0011 + 16'(i) * 16'h2222);
    chk("key_value", core_key, 128'h00112233445566778899aabbccddeeff);
    chk("key_loaded_full", key_loaded, 1);
    block(64'h0123_4567_89ab_cdef);
    drain();

    // Backpressure
    bp_hold = 1;
    block(64'hdead_beef_0bad_f00d);
    for (int n = 0; n < 50 && out_valid !== 1'b1; n++) tick();
    chk("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    bp_hold = 0;
    drain();

    // Interleave key word into a partial block
    send(0, 16'haaaa);
    send(0, 16'hbbbb);
    send(1, 16'h1234);
    chk("interleave_key_loaded", key_loaded, 0);
    block(64'h5555_6666_7777_8888);
    drain();
    for (int i = 1; i < 8; i++) send(1, 16'($urandom));
    chk("rekey_loaded", key_loaded, 1);

    // Key reuse, back-to-back
    start_hist.delete();
    block({$urandom, $urandom});
    block({$urandom, $urandom});
    drain();
    chk("start_count", start_hist.size(), 2);
    if (start_hist.size() >= 2)
      chk("start_period", start_hist[1] - start_hist[0], 4 + 1 + LAT + 1);

    // Reset during WAIT with wcnt==1
    block({$urandom, $urandom});
    for (int n = 0; n < 20 && core_start !== 1'b1; n++) tick();
    chk("mid_start_seen", core_start, 1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("mid_in_ready", in_ready, 0);
    chk("mid_core_start", core_start, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_key_loaded", key_loaded, 0);
    chk("mid_err", err, 0);
    chk("mid_core_key", core_key, 0);
    vt_q.delete();
    ct_q.delete();
    start_q.delete();
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mid_release_in_ready", in_ready, 1);
    repeat (10) tick();
    chk("mid_no_out_valid", out_valid, 0);

    // Randomized traffic
    rnd = 1;
    for (int i = 0; i < 60; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 2) begin
        for (int j = 0; j < 8; j++) send(1, 16'($urandom));
      end else if (r < 8) begin
        block({$urandom, $urandom});
      end else begin
        send(1'($urandom_range(0, 1)), 16'($urandom));
      end
    end
    drain();
    rnd = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
